// File: rtl/pixel_word_sequencer.sv
// Fetches pixel words over valid/ready, double-buffers them and shifts them out one bit per pix_en tick.
// Optional macro PIXEL_MIRROR_EN adds the mirror input and the bit-reversal mux in the fetch path.
module pixel_word_sequencer #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 20,
    parameter int CNT_W          = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic              pix_en,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
`ifdef PIXEL_MIRROR_EN
    input  logic              mirror,
`endif
    output logic              pix_out,
    output logic              pix_active,
    output logic              underrun,
    output logic              line_done,
    // FSM state for checkers: 0 IDLE, 1 PRIME, 2 RUN, 3 DONE
    output logic [1:0]        state_dbg
);

    localparam int WC_W = $clog2(WORDS_PER_LINE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [WORD_W-1:0] hold;
    logic              hold_full;
    logic [WORD_W-1:0] shift;
    logic [CNT_W-1:0]  bit_idx;
    logic [WC_W-1:0]   words_fetched;
    logic [WC_W-1:0]   words_shown;
    logic [WORD_W-1:0] word_in;
    logic              handshake;

`ifdef PIXEL_MIRROR_EN
    logic              mirror_q;
    logic [WORD_W-1:0] word_rev;

    always_comb begin
        word_rev = '0;
        for (int i = 0; i < WORD_W; i++) begin
            word_rev[i] = word_data[WORD_W-1-i];
        end
    end

    assign word_in = mirror_q ? word_rev : word_data;
`else
    assign word_in = word_data;
`endif

    // Handshake: a word transfers on every cycle with word_valid && word_ready.
    // word_ready depends only on registered state, never on word_valid.
    assign word_ready = ((state == PRIME) || (state == RUN)) && !hold_full &&
                        (words_fetched < WC_W'(WORDS_PER_LINE));
    assign handshake  = word_valid && word_ready;

    assign pix_active = (state == RUN);
    assign pix_out    = (state == RUN) && shift[WORD_W-1];
    assign line_done  = (state == DONE);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            hold          <= '0;
            hold_full     <= 1'b0;
            shift         <= '0;
            bit_idx       <= '0;
            words_fetched <= '0;
            words_shown   <= '0;
            underrun      <= 1'b0;
`ifdef PIXEL_MIRROR_EN
            mirror_q      <= 1'b0;
`endif
        end else begin
            underrun <= 1'b0;
            if (line_start) begin
                // Starting or aborting a line: any word offered this cycle is dropped with the flush.
                state         <= PRIME;
                hold_full     <= 1'b0;
                shift         <= '0;
                bit_idx       <= '0;
                words_fetched <= '0;
                words_shown   <= '0;
`ifdef PIXEL_MIRROR_EN
                mirror_q      <= mirror;
`endif
            end else begin
                case (state)
                    IDLE: begin
                    end
                    PRIME: begin
                        if (hold_full) begin
                            shift     <= hold;
                            hold_full <= 1'b0;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (pix_en) begin
                            shift   <= shift << 1;
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == {CNT_W{1'b1}}) begin
                                words_shown <= words_shown + 1'b1;
                                if (words_shown == WC_W'(WORDS_PER_LINE - 1)) begin
                                    state <= DONE;
                                end else if (hold_full) begin
                                    shift     <= hold;
                                    hold_full <= 1'b0;
                                end else begin
                                    // Empty slot: emit blank pixels, a late word fills the next slot.
                                    shift    <= '0;
                                    underrun <= 1'b1;
                                end
                            end
                        end
                    end
                    DONE: begin
                        hold_full <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase

                // Placed after the case so a same-cycle refill wins over the reload's clear.
                if (handshake) begin
                    hold          <= word_in;
                    hold_full     <= 1'b1;
                    words_fetched <= words_fetched + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_word_sequencer.sv
// Randomized scoreboard bench for pixel_word_sequencer; expected pixels come from a word-level line model.
// Builds with or without PIXEL_MIRROR_EN.
module tb_pixel_word_sequencer;

    localparam int W   = 32;
    localparam int WPL = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         line_start;
    logic         pix_en;
    logic [W-1:0] word_data;
    logic         word_valid;
    logic         word_ready;
`ifdef PIXEL_MIRROR_EN
    logic         mirror;
`endif
    logic         pix_out;
    logic         pix_active;
    logic         underrun;
    logic         line_done;
    logic [1:0]   state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic exp_q[$];
    int   line_ticks = 0;
    int   ld_count   = 0;
    int   ur_count   = 0;
    int   ur_tick    = -1;
    logic mon_exp;

    pixel_word_sequencer #(.WORD_W(W), .WORDS_PER_LINE(WPL), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .line_start (line_start),
        .pix_en     (pix_en),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
`ifdef PIXEL_MIRROR_EN
        .mirror     (mirror),
`endif
        .pix_out    (pix_out),
        .pix_active (pix_active),
        .underrun   (underrun),
        .line_done  (line_done),
        .state_dbg  (state_dbg)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic void check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference: a displayed word is the source word, bit-reversed when the line is mirrored.
    function automatic logic [W-1:0] model_word(input logic [W-1:0] w, input bit m);
        logic [W-1:0] r;
        r = w;
        if (m) begin
            for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        end
        return r;
    endfunction

    task automatic drive_mirror(input bit m);
`ifdef PIXEL_MIRROR_EN
        mirror = m;
`else
        if (m) $display("mirror request ignored in this build");
`endif
    endtask

    // Monitor: every consumed pixel (pix_en while active) is popped and compared.
    always @(negedge clk) begin
        if (reset || line_start) begin
            line_ticks = 0;
        end else begin
            if (underrun) begin
                ur_count++;
                ur_tick = line_ticks;
            end
            if (line_done) begin
                ld_count++;
                check_int("done_after_last_tick", line_ticks, WPL * W);
                check1("ready_low_in_done", word_ready, 1'b0);
                check1("active_low_in_done", pix_active, 1'b0);
            end
            if (!pix_active) check1("pix_out_idle_zero", pix_out, 1'b0);
            if (pix_active && pix_en) begin
                if (exp_q.size() == 0) begin
                    check1("pix_extra", 1'b1, 1'b0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check1("pix", pix_out, mon_exp);
                end
                line_ticks++;
            end
        end
    end

    // Driver for one line. cut_kind: 0 none, 1 abort via line_start, 2 reset (both at tick cut_at).
    task automatic run_line(input logic [W-1:0] words[WPL+1], input bit mir_req, input bit do_start,
                            input int gap_max, input int pen_max, input int hold_idx,
                            input int hold_cycles, input int ur_slot, input int cut_kind,
                            input int cut_at);
        int idx = 0, gap = 0, hs_count = 0, cyc = 0, since_hs = -1;
        int ld0, ur0;
        bit hs, done = 0, mir;
        logic [W-1:0] mw;
`ifdef PIXEL_MIRROR_EN
        mir = mir_req;
`else
        mir = 1'b0;
`endif
        ld0 = ld_count;
        ur0 = ur_count;
        for (int slot = 0; slot < WPL; slot++) begin
            if (slot == ur_slot) mw = '0;
            else mw = model_word(words[(ur_slot >= 0 && slot > ur_slot) ? slot - 1 : slot], mir);
            for (int b = W - 1; b >= 0; b--) exp_q.push_back(mw[b]);
        end
        if (do_start) begin
            line_start = 1'b1;
            drive_mirror(mir);
            word_valid = 1'b0;
            pix_en     = 1'b0;
            @(posedge clk); #1;
            line_start = 1'b0;
        end
        while (!done && cyc < 3000) begin
            if (cut_kind != 0 && line_ticks == cut_at) begin
                exp_q.delete();
                word_valid = 1'b0;
                pix_en     = 1'b0;
                if (cut_kind == 1) begin
                    line_start = 1'b1;
                    drive_mirror(1'b0);
                    @(posedge clk); #1;
                    line_start = 1'b0;
                    check_int("abort_state_prime", int'(state_dbg), 1);
                    check1("abort_ready", word_ready, 1'b1);
                    check1("abort_active_low", pix_active, 1'b0);
                    check_int("abort_no_line_done", ld_count, ld0);
                    check_int("abort_no_underrun", ur_count, ur0);
                end else begin
                    reset      = 1'b1;
                    line_start = 1'b1;
                    word_valid = 1'b1;
                    word_data  = 32'hDEAD_BEEF;
                    @(posedge clk); #1;
                    check_int("rst_state_idle", int'(state_dbg), 0);
                    check1("rst_pix_out", pix_out, 1'b0);
                    check1("rst_pix_active", pix_active, 1'b0);
                    check1("rst_underrun", underrun, 1'b0);
                    check1("rst_line_done", line_done, 1'b0);
                    check1("rst_word_ready", word_ready, 1'b0);
                    reset      = 1'b0;
                    line_start = 1'b0;
                    word_valid = 1'b0;
                    @(posedge clk); #1;
                    check1("post_rst_ready_idle", word_ready, 1'b0);
                end
                return;
            end
            if (since_hs == 1) check1("prime_not_active", pix_active, 1'b0);
            if (since_hs == 2) check1("first_pixel_latency", pix_active, 1'b1);
            if (gap > 0) begin
                word_valid = 1'b0;
                gap--;
            end else begin
                word_valid = (idx < WPL + 1);
            end
            word_data = (idx < WPL + 1) ? words[idx] : $urandom;
            pix_en    = ($urandom_range(0, pen_max) == 0);
            @(negedge clk);
            hs = word_valid && word_ready;
            if (line_done) done = 1;
            @(posedge clk); #1;
            if (since_hs >= 0) since_hs++;
            if (hs) begin
                if (hs_count == 0) since_hs = 1;
                hs_count++;
                idx++;
                gap = (idx == hold_idx) ? hold_cycles : $urandom_range(0, gap_max);
            end
            cyc++;
        end
        word_valid = 1'b0;
        pix_en     = 1'b0;
        check1("line_completed", done, 1'b1);
        check_int("transfers_per_line", hs_count, WPL);
        check_int("line_done_pulses", ld_count - ld0, 1);
        check_int("underrun_pulses", ur_count - ur0, (ur_slot >= 0) ? 1 : 0);
        if (ur_slot >= 0) check_int("underrun_tick", ur_tick, ur_slot * W);
        check_int("pixels_left", exp_q.size(), 0);
        check_int("idle_after_done", int'(state_dbg), 0);
        check1("ready_low_idle", word_ready, 1'b0);
    endtask

    initial begin
        logic [W-1:0] wl[WPL+1];
        reset      = 1'b1;
        line_start = 1'b0;
        pix_en     = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        drive_mirror(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_state", int'(state_dbg), 0);
        check1("reset_pix_out", pix_out, 1'b0);
        check1("reset_pix_active", pix_active, 1'b0);
        check1("reset_underrun", underrun, 1'b0);
        check1("reset_line_done", line_done, 1'b0);
        check1("reset_word_ready", word_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check1("idle_ready_low", word_ready, 1'b0);

        // Known pattern, source always valid, pixel tick every cycle.
        wl = '{32'h8000_0001, 32'hFFFF_0000, 32'h1234_5678, 32'hAAAA_AAAA};
        run_line(wl, 1'b0, 1'b1, 0, 0, -1, 0, -1, 0, 0);

`ifdef PIXEL_MIRROR_EN
        wl = '{32'h0000_0003, 32'h0F00_00F1, 32'h8000_0000, 32'h5555_5555};
        run_line(wl, 1'b1, 1'b1, 0, 0, -1, 0, -1, 0, 0);
`endif

        // Second word held back 40 cycles: slot 1 blank, it shows in slot 2.
        wl = '{32'hC3C3_C3C3, 32'hF0F0_0F0F, 32'h0123_4567, 32'h89AB_CDEF};
        run_line(wl, 1'b0, 1'b1, 0, 0, 1, 40, 1, 0, 0);

        // Abort at bit 10 of the first word, then the new line runs from its first word.
        wl = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_line(wl, 1'b0, 1'b1, 0, 0, -1, 0, -1, 1, 10);
        wl = '{32'h0000_FFFF, 32'h1357_9BDF, 32'h2468_ACE0, 32'h7777_7777};
        run_line(wl, 1'b0, 1'b0, 0, 0, -1, 0, -1, 0, 0);

        // Reset in RUN together with line_start and word_valid.
        wl = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h3C3C_3C3C, 32'hC3C3_3C3C};
        run_line(wl, 1'b0, 1'b1, 0, 0, -1, 0, -1, 2, 40);
        wl = '{32'h0F0F_0F0F, 32'hF00F_F00F, 32'h6969_9696, 32'h1111_8888};
        run_line(wl, 1'b0, 1'b1, 0, 0, -1, 0, -1, 0, 0);

        // Random words, gaps, tick densities and mirror settings.
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < WPL + 1; k++) wl[k] = $urandom;
            run_line(wl, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 6),
                     $urandom_range(0, 3), -1, 0, -1, 0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
